ita_output_drain: RTL and testbench

- Consumer end of the ITA output FIFO: pops N*WI-bit requantized rows (N lanes of WI-bit int8) and serializes them onto a narrower valid/ready output stream.
- Each start drains a programmed number of FIFO entries, flags the final beat, and reports completion.
- Sits between the output FIFO (producer side: requantizer) and the system output interface / HWPE streamer.

---
 rtl/ita_output_drain.sv | 101 ++++++++++
 tb/tb_ita_output_drain.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ita_output_drain.sv
// Output FIFO drain: pops N*WI-bit entries and serializes each one into
// N*WI/OutWidth beats on a valid/ready stream, lowest lanes first.
module ita_output_drain #(
  parameter int unsigned N          = 16,
  parameter int unsigned WI         = 8,
  parameter int unsigned OutWidth   = 32,
  parameter int unsigned CountWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [CountWidth-1:0] n_entries_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  fifo_valid_i,
  input  logic [N*WI-1:0]       fifo_data_i,
  output logic                  fifo_pop_o,
  output logic                  oup_valid_o,
  input  logic                  oup_ready_i,
  output logic [OutWidth-1:0]   oup_data_o,
  output logic                  oup_last_o
);

  localparam int unsigned EntryWidth = N * WI;
  localparam int unsigned Beats      = EntryWidth / OutWidth;
  localparam int unsigned BeatWidth  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(Beats - 1);

  localparam logic [1:0] Idle  = 2'd0;
  localparam logic [1:0] Drain = 2'd1;
  localparam logic [1:0] Done  = 2'd2;

  logic [1:0]                         state, state_next;
  logic [CountWidth-1:0]              n_q, pop_cnt;
  logic [BeatWidth-1:0]               beat_cnt;
  logic [Beats-1:0][OutWidth-1:0]     hold_buf;
  logic                               hold_valid;
  logic                               handshake, at_last_beat, pop;

  assign handshake    = hold_valid && oup_ready_i;
  assign at_last_beat = (beat_cnt == LastBeat);

  // Refill on the last-beat handshake so consecutive entries stream without a bubble.
  assign pop = (state == Drain) && fifo_valid_i && (pop_cnt < n_q) &&
               (!hold_valid || (handshake && at_last_beat));

  assign fifo_pop_o  = pop;
  assign oup_valid_o = hold_valid;
  assign oup_data_o  = hold_buf[beat_cnt];
  assign oup_last_o  = hold_valid && at_last_beat && (pop_cnt == n_q);
  assign busy_o      = (state == Drain);
  assign done_o      = (state == Done);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= Idle;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      Idle:    if (start_i) state_next = (n_entries_i == '0) ? Done : Drain;
      Drain:   if (handshake && oup_last_o) state_next = Done;
      Done:    state_next = Idle;
      default: state_next = Idle;
    endcase
  end

  // Job counters and the single-entry holding buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_q        <= '0;
      pop_cnt    <= '0;
      beat_cnt   <= '0;
      hold_buf   <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (state == Idle && start_i) begin
        n_q      <= n_entries_i;
        pop_cnt  <= '0;
        beat_cnt <= '0;
      end
      if (pop) begin
        hold_buf   <= fifo_data_i;
        hold_valid <= 1'b1;
        pop_cnt    <= pop_cnt + CountWidth'(1);
        beat_cnt   <= '0;
      end else if (handshake) begin
        if (!at_last_beat) begin
          beat_cnt <= beat_cnt + BeatWidth'(1);
        end else begin
          hold_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ita_output_drain.sv
// Directed bench for ita_output_drain: FIFO model with per-entry byte bases,
// beat-by-beat data/last checks, pop spacing, backpressure, starvation and reset.
module tb_ita_output_drain;

  localparam int unsigned BEATS = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [31:0]  n_entries_i;
  logic         busy_o, done_o;
  logic         fifo_valid_i;
  logic [127:0] fifo_data_i;
  logic         fifo_pop_o;
  logic         oup_valid_o;
  logic         oup_ready_i;
  logic [31:0]  oup_data_o;
  logic         oup_last_o;

  logic [127:0] mem   [0:31];
  logic [7:0]   bases [0:31];
  int           rd_ptr = 0;
  int           wr_ptr = 0;
  int           vectors = 0;
  int           miscompares = 0;
  int           idle;

  ita_output_drain dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .n_entries_i  (n_entries_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .fifo_valid_i (fifo_valid_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_pop_o   (fifo_pop_o),
    .oup_valid_o  (oup_valid_o),
    .oup_ready_i  (oup_ready_i),
    .oup_data_o   (oup_data_o),
    .oup_last_o   (oup_last_o)
  );

  always #5 clk_i = ~clk_i;

  assign fifo_valid_i = (rd_ptr != wr_ptr);
  assign fifo_data_i  = mem[rd_ptr[4:0]];

  always @(posedge clk_i) if (fifo_pop_o) rd_ptr <= rd_ptr + 1;

  function automatic logic [127:0] make_entry(input logic [7:0] base);
    logic [127:0] e;
    for (int k = 0; k < 16; k++) e[k*8 +: 8] = base + 8'(k);
    return e;
  endfunction

  function automatic logic [31:0] exp_beat(input logic [7:0] base, input int j);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = base + 8'(4*j + b);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] base);
    mem[wr_ptr[4:0]]   = make_entry(base);
    bases[wr_ptr[4:0]] = base;
    wr_ptr++;
  endtask

  task automatic start_job(input string tag, input int n);
    @(negedge clk_i);
    start_i = 1'b1;
    n_entries_i = 32'(n);
    #1 chk({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Called at the negedge of the first Drain cycle; returns after done_o falls.
  task automatic drain(input string tag, input int n_ent, input bit strict,
                       input int push_at, input logic [7:0] late_base,
                       input int pulse_at, output int idle_cnt);
    int beat, cyc_i, first_pop, npop, first, total;
    first = rd_ptr; total = n_ent * BEATS;
    beat = 0; cyc_i = 0; first_pop = -1; npop = 0; idle_cnt = 0;
    while (beat < total && cyc_i < 200) begin
      if (cyc_i == push_at) push(late_base);
      start_i = (cyc_i == pulse_at);
      if (cyc_i == pulse_at) n_entries_i = 32'd5;
      #1;
      chk({tag, "_busy"}, 32'(busy_o), 32'd1);
      if (fifo_pop_o) begin
        if (first_pop < 0) first_pop = cyc_i;
        if (strict) chk({tag, "_pop_phase"}, 32'(cyc_i - first_pop), 32'(npop * BEATS));
        npop++;
      end
      if (oup_valid_o && oup_ready_i) begin
        chk({tag, "_data"}, oup_data_o, exp_beat(bases[(first + beat / BEATS) % 32], beat % BEATS));
        chk({tag, "_last"}, 32'(oup_last_o), 32'(beat == total - 1));
        beat++;
      end else if (first_pop >= 0 && cyc_i > first_pop && !oup_valid_o) begin
        idle_cnt++;
      end
      cyc_i++;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    chk({tag, "_beats"}, 32'(beat), 32'(total));
    chk({tag, "_pops"}, 32'(npop), 32'(n_ent));
    #1;
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_done_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done_valid"}, 32'(oup_valid_o), 32'd0);
    @(negedge clk_i);
    #1 chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0;
    start_i = 1'b0;
    n_entries_i = '0;
    oup_ready_i = 1'b1;
    #2;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_pop", 32'(fifo_pop_o), 32'd0);
    chk("rst_valid", 32'(oup_valid_o), 32'd0);
    chk("rst_last", 32'(oup_last_o), 32'd0);
    chk("rst_data", oup_data_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single entry, lanes 0x00..0x0F.
    push(8'h00);
    start_job("basic", 1);
    drain("basic", 1, 1'b1, -1, 8'h00, -1, idle);
    chk("basic_idle", 32'(idle), 32'd0);

    // Three back-to-back entries plus one excess entry that must stay queued.
    push(8'h10); push(8'h20); push(8'h30); push(8'h00);
    start_job("stream", 3);
    drain("stream", 3, 1'b1, -1, 8'h00, -1, idle);
    chk("stream_idle", 32'(idle), 32'd0);
    chk("stream_leftover", 32'(wr_ptr - rd_ptr), 32'd1);

    // Backpressure on the second beat of the leftover 0x00 entry.
    start_job("bp", 1);
    #1 chk("bp_pop", 32'(fifo_pop_o), 32'd1);
    @(negedge clk_i);
    #1 chk("bp_beat0", oup_data_o, 32'h03020100);
    @(negedge clk_i);
    oup_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_data", oup_data_o, 32'h07060504);
      chk("bp_hold_valid", 32'(oup_valid_o), 32'd1);
      chk("bp_hold_last", 32'(oup_last_o), 32'd0);
      chk("bp_hold_nopop", 32'(fifo_pop_o), 32'd0);
      @(negedge clk_i);
    end
    oup_ready_i = 1'b1;
    for (int j = 1; j < 4; j++) begin
      #1;
      chk("bp_resume_data", oup_data_o, exp_beat(8'h00, j));
      chk("bp_resume_last", 32'(oup_last_o), 32'(j == 3));
      @(negedge clk_i);
    end
    #1 chk("bp_done", 32'(done_o), 32'd1);

    // Starvation: second entry only shows up at drain cycle 10.
    push(8'h50);
    start_job("starve", 2);
    drain("starve", 2, 1'b0, 10, 8'hA0, -1, idle);
    chk("starve_idle", 32'(idle), 32'd6);

    // Zero-length job with entries waiting in the FIFO.
    push(8'h60); push(8'h70);
    start_job("zero", 0);
    #1;
    chk("zero_done", 32'(done_o), 32'd1);
    chk("zero_pop", 32'(fifo_pop_o), 32'd0);
    chk("zero_valid", 32'(oup_valid_o), 32'd0);
    chk("zero_busy", 32'(busy_o), 32'd0);

    // A start pulse mid-job must not change the entry count.
    start_job("midstart", 1);
    drain("midstart", 1, 1'b1, -1, 8'h00, 2, idle);
    chk("midstart_leftover", 32'(wr_ptr - rd_ptr), 32'd1);

    // Reset during the second beat of the second entry.
    push(8'h80);
    start_job("rstmid", 4);
    repeat (6) @(negedge clk_i);
    #1 chk("rstmid_pre_data", oup_data_o, exp_beat(8'h80, 1));
    rst_ni = 1'b0;
    #1;
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    chk("rstmid_done", 32'(done_o), 32'd0);
    chk("rstmid_pop", 32'(fifo_pop_o), 32'd0);
    chk("rstmid_valid", 32'(oup_valid_o), 32'd0);
    chk("rstmid_last", 32'(oup_last_o), 32'd0);
    chk("rstmid_data", oup_data_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    push(8'h90);
    start_job("after_rst", 1);
    drain("after_rst", 1, 1'b1, -1, 8'h00, -1, idle);
    chk("after_rst_empty", 32'(wr_ptr - rd_ptr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
